// File: rtl/bec_key_sequencer_pkg.sv
// Shared definitions for the binary Edwards curve key sequencer and the
// scalar-multiplication core it feeds.
package bec_key_sequencer_pkg;

  // Scalar width, also the number of ladder iterations the core performs.
  localparam int BEC_KEY_W = 163;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } seq_state_e;

endpackage

// File: rtl/bec_key_shiftreg.sv
// Loadable MSB-first shift register; msb is the key bit currently served
// to the core.
module bec_key_shiftreg #(
  parameter int W = 163
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] key_r;

  // Scalar storage: load wins over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= {W{1'b0}};
    end else if (load) begin
      key_r <= din;
    end else if (shift) begin
      key_r <= {key_r[W-2:0], 1'b0};
    end else begin
      key_r <= key_r;
    end
  end

  assign msb = key_r[W-1];

endmodule

// File: rtl/bec_key_sequencer.sv
// Host-side controller for the Edwards curve scalar-multiplication core:
// serves key bits per ladder iteration and returns wout/zout to the host.
module bec_key_sequencer
  import bec_key_sequencer_pkg::*;
#(
  parameter int KEY_W = BEC_KEY_W,
  parameter int TO_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             abort,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [KEY_W-1:0] res_w,
  output logic [KEY_W-1:0] res_z,
  output logic             res_err,
  output logic             sm_enable,
  output logic             sm_ki,
  input  logic             sm_next_key,
  input  logic             sm_done,
  input  logic [KEY_W-1:0] sm_wout,
  input  logic [KEY_W-1:0] sm_zout
);

  localparam int ITER_W = $clog2(KEY_W);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(KEY_W - 1);
  // The decision is registered, so firing two counts early makes res_valid
  // rise exactly 2^TO_W-1 cycles after the last next_key.
  localparam logic [TO_W-1:0] WDOG_LIMIT = {TO_W{1'b1}} - TO_W'(2);

  seq_state_e        state_r;
  seq_state_e        state_nx_s;
  logic [ITER_W-1:0] iter_r;
  logic [ITER_W-1:0] iter_nx_s;
  logic [TO_W-1:0]   wdog_r;
  logic [TO_W-1:0]   wdog_nx_s;
  logic              load_s;
  logic              shift_s;
  logic              last_s;
  logic              wdog_hit_s;
  logic              enable_nx_s;
  logic              valid_nx_s;
  logic              busy_nx_s;
  logic              err_nx_s;
  logic [KEY_W-1:0]  w_nx_s;
  logic [KEY_W-1:0]  z_nx_s;

  assign last_s     = (iter_r == ITER_LAST);
  assign wdog_hit_s = (wdog_r == WDOG_LIMIT);

  bec_key_shiftreg #(
    .W (KEY_W)
  ) u_shiftreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .shift (shift_s),
    .din   (key),
    .msb   (sm_ki)
  );

  // State, counters and all host/core-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      iter_r    <= {ITER_W{1'b0}};
      wdog_r    <= {TO_W{1'b0}};
      sm_enable <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      res_err   <= 1'b0;
      res_w     <= {KEY_W{1'b0}};
      res_z     <= {KEY_W{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      iter_r    <= iter_nx_s;
      wdog_r    <= wdog_nx_s;
      sm_enable <= enable_nx_s;
      res_valid <= valid_nx_s;
      busy      <= busy_nx_s;
      res_err   <= err_nx_s;
      res_w     <= w_nx_s;
      res_z     <= z_nx_s;
    end
  end

  // Next-state decode; abort outranks every core or host event.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (sm_next_key && !sm_done && !last_s) begin
          state_nx_s = ST_RUN;
        end else if (sm_done || sm_next_key || wdog_hit_s) begin
          state_nx_s = ST_HOLD;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (abort || res_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    load_s      = 1'b0;
    shift_s     = 1'b0;
    iter_nx_s   = iter_r;
    wdog_nx_s   = wdog_r;
    enable_nx_s = sm_enable;
    valid_nx_s  = res_valid;
    busy_nx_s   = busy;
    err_nx_s    = res_err;
    w_nx_s      = res_w;
    z_nx_s      = res_z;
    case (state_r)
      ST_IDLE: begin
        valid_nx_s = 1'b0;
        if (start) begin
          load_s      = 1'b1;
          iter_nx_s   = {ITER_W{1'b0}};
          wdog_nx_s   = {TO_W{1'b0}};
          enable_nx_s = 1'b1;
          busy_nx_s   = 1'b1;
        end else begin
          enable_nx_s = 1'b0;
          busy_nx_s   = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          enable_nx_s = 1'b0;
          valid_nx_s  = 1'b0;
          busy_nx_s   = 1'b0;
        end else if (sm_next_key && !sm_done && !last_s) begin
          shift_s   = 1'b1;
          iter_nx_s = iter_r + ITER_W'(1);
          wdog_nx_s = {TO_W{1'b0}};
        end else if (sm_next_key && sm_done && last_s) begin
          enable_nx_s = 1'b0;
          valid_nx_s  = 1'b1;
          err_nx_s    = 1'b0;
          w_nx_s      = sm_wout;
          z_nx_s      = sm_zout;
        end else if (sm_done || sm_next_key || wdog_hit_s) begin
          // Count mismatch or stalled core: report an invalid, zeroed result.
          enable_nx_s = 1'b0;
          valid_nx_s  = 1'b1;
          err_nx_s    = 1'b1;
          w_nx_s      = {KEY_W{1'b0}};
          z_nx_s      = {KEY_W{1'b0}};
        end else begin
          wdog_nx_s = wdog_r + TO_W'(1);
        end
      end
      ST_HOLD: begin
        enable_nx_s = 1'b0;
        if (abort || res_ready) begin
          valid_nx_s = 1'b0;
          busy_nx_s  = 1'b0;
        end else begin
          valid_nx_s = 1'b1;
          busy_nx_s  = 1'b1;
        end
      end
      default: begin
        enable_nx_s = 1'b0;
        valid_nx_s  = 1'b0;
        busy_nx_s   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bec_key_sequencer.sv
// Directed bench for bec_key_sequencer: table of full jobs plus hand-written
// timeout, backpressure, abort and reset sequences.
module tb_bec_key_sequencer;

  localparam int KW = 163;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, abort, res_ready, sm_next_key, sm_done;
  logic [KW-1:0] key, sm_wout, sm_zout;
  logic          busy, res_valid, res_err, sm_enable, sm_ki;
  logic [KW-1:0] res_w, res_z;

  logic          t_start, t_next, t_ready, t_abort, t_done;
  logic          t_busy, t_valid, t_err, t_en, t_ki;
  logic [KW-1:0] t_w, t_z;

  int checks = 0;
  int errors = 0;

  bec_key_sequencer #(.KEY_W(KW), .TO_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .abort(abort),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_w(res_w), .res_z(res_z), .res_err(res_err),
    .sm_enable(sm_enable), .sm_ki(sm_ki), .sm_next_key(sm_next_key),
    .sm_done(sm_done), .sm_wout(sm_wout), .sm_zout(sm_zout)
  );

  bec_key_sequencer #(.KEY_W(KW), .TO_W(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(t_start), .key(key), .abort(t_abort),
    .busy(t_busy), .res_valid(t_valid), .res_ready(t_ready),
    .res_w(t_w), .res_z(t_z), .res_err(t_err),
    .sm_enable(t_en), .sm_ki(t_ki), .sm_next_key(t_next),
    .sm_done(t_done), .sm_wout(sm_wout), .sm_zout(sm_zout)
  );

  typedef struct {
    logic [KW-1:0] key;
    int            npulse;
    int            done_at;
    logic [KW-1:0] wout;
    logic [KW-1:0] zout;
    logic          exp_err;
    logic [KW-1:0] exp_w;
    logic [KW-1:0] exp_z;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [KW-1:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("enable_after_start", sm_enable, 1'b1);
    chk("busy_after_start", busy, 1'b1);
  endtask

  // Core model: pulse next_key every gap cycles, checking the served bit first.
  task automatic pulses(input logic [KW-1:0] k, input int n, input int done_at, input int gap);
    for (int p = 1; p <= n; p++) begin
      repeat (gap - 1) tick();
      chk($sformatf("ki_iter%0d", p - 1), sm_ki, k[KW-p]);
      sm_next_key = 1'b1;
      sm_done     = (p == done_at);
      tick();
      sm_next_key = 1'b0;
      sm_done     = 1'b0;
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    sm_wout = v.wout;
    sm_zout = v.zout;
    launch(v.key);
    pulses(v.key, v.npulse, v.done_at, 20);
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_err"}, res_err, v.exp_err);
    chk({tag, "_w"}, res_w, v.exp_w);
    chk({tag, "_z"}, res_z, v.exp_z);
    chk({tag, "_enable_low"}, sm_enable, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, res_valid, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [KW-1:0] ones, msb_only, alt, other;
    int cyc, bad, rises;

    ones     = {KW{1'b1}};
    msb_only = {1'b1, {(KW-1){1'b0}}};
    alt      = {1'b0, {81{2'b10}}};
    other    = {2'b01, {(KW-2){1'b1}}};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    sm_next_key = 1'b0; sm_done = 1'b0; key = '0; sm_wout = '0; sm_zout = '0;
    t_start = 1'b0; t_next = 1'b0; t_ready = 1'b0; t_abort = 1'b0; t_done = 1'b0;
    repeat (3) tick();
    chk("rst_enable", sm_enable, 1'b0);
    chk("rst_ki", sm_ki, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_err", res_err, 1'b0);
    chk("rst_w", res_w, '0);
    chk("rst_z", res_z, '0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{ones,     163, 163, 163'd1, 163'd2, 1'b0, 163'd1, 163'd2};
    vecs[1] = '{msb_only, 163, 163, 163'd3, 163'd4, 1'b0, 163'd3, 163'd4};
    vecs[2] = '{alt,      163, 163, 163'h5a, 163'ha5, 1'b0, 163'h5a, 163'ha5};
    vecs[3] = '{ones,     100, 100, 163'd7, 163'd9, 1'b1, 163'd0, 163'd0};
    vecs[4] = '{alt,      163, 0,   163'd7, 163'd9, 1'b1, 163'd0, 163'd0};
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Timeout on the TO_W=4 instance: stall after three pulses.
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick();
      t_next = 1'b1;
      tick();
      t_next = 1'b0;
    end
    cyc = 1;
    while (!t_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("timeout_cycles", cyc, 15);
    chk("timeout_err", t_err, 1'b1);
    chk("timeout_enable", t_en, 1'b0);
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;
    chk("timeout_valid_drop", t_valid, 1'b0);

    // Backpressure: result held while start is ignored, then start across handshake.
    sm_wout = 163'hab;
    sm_zout = 163'hcd;
    launch(ones);
    pulses(ones, 163, 163, 2);
    chk("bp_valid", res_valid, 1'b1);
    key   = other;
    start = 1'b1;
    bad   = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_w !== 163'hab || res_z !== 163'hcd ||
          res_err !== 1'b0 || sm_enable !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    chk("bp_hold_stable", bad, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_valid_drop", res_valid, 1'b0);
    chk("bp_start_not_taken", sm_enable, 1'b0);
    tick();
    start = 1'b0;
    chk("bp_restart_enable", sm_enable, 1'b1);
    chk("bp_restart_ki", sm_ki, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_enable", sm_enable, 1'b0);
    chk("abort_run_busy", busy, 1'b0);

    // Abort coinciding with the final pulse and done.
    launch(ones);
    pulses(ones, 162, 0, 2);
    tick();
    sm_next_key = 1'b1; sm_done = 1'b1; abort = 1'b1;
    tick();
    sm_next_key = 1'b0; sm_done = 1'b0; abort = 1'b0;
    chk("abort_final_enable", sm_enable, 1'b0);
    chk("abort_final_busy", busy, 1'b0);
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid !== 1'b0) rises++;
      tick();
    end
    chk("abort_final_no_valid", rises, 0);

    // Asynchronous reset at iteration 80, then a clean full job.
    sm_wout = 163'd1;
    sm_zout = 163'd2;
    launch(ones);
    pulses(ones, 80, 0, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", sm_enable, 1'b0);
    chk("midrst_ki", sm_ki, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", res_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run_job(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
